// File: rtl/risc32_regfile_pkg.sv
// Shared constants and defaults for the risc32 register file slice.
package risc32_regfile_pkg;

   localparam int RF_DATA_W   = 32;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;
   localparam int RF_CNT_W    = 32;

   typedef logic [RF_DATA_W-1:0] reg_bus_t;
   typedef logic [RF_ADDR_W-1:0] reg_addr_t;

   localparam reg_bus_t ZERO_WORD    = '0;
   localparam logic     WRITE_ENABLE = 1'b1;
   localparam logic     READ_ENABLE  = 1'b1;

endpackage

// File: rtl/risc32_regfile_if.sv
// Write-back commit, GPR read and HI/LO signals between the pipeline and the register file.
interface risc32_regfile_if
   import risc32_regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata2;
   logic              whilo;
   logic [DATA_W-1:0] hi_i;
   logic [DATA_W-1:0] lo_i;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;

   modport master (
      output we, waddr, wdata, re1, raddr1, re2, raddr2, whilo, hi_i, lo_i,
      input  rdata1, rdata2, hi_o, lo_o
   );

   modport slave (
      input  we, waddr, wdata, re1, raddr1, re2, raddr2, whilo, hi_i, lo_i,
      output rdata1, rdata2, hi_o, lo_o
   );
endinterface

// File: rtl/risc32_hilo_reg.sv
// HI/LO register pair with asynchronous clear, write enable and same-cycle write-through.
module risc32_hilo_reg
   import risc32_regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              whilo,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (whilo == WRITE_ENABLE) begin
         hi_q <= hi_i;
         lo_q <= lo_i;
      end
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (rst_n) begin
         hi_o = (whilo == WRITE_ENABLE) ? hi_i : hi_q;
         lo_o = (whilo == WRITE_ENABLE) ? lo_i : lo_q;
      end
   end

endmodule

// File: rtl/risc32_regfile.sv
// GPR file (r0 hard-wired to zero) plus HI/LO, with write-through bypass on every read port.
// Optional debug read port and write counter are enabled by defining RISC32_RF_DBG_EN.
module risc32_regfile
   import risc32_regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS
)(
   input  logic                clk,
   input  logic                rst_n,
`ifdef RISC32_RF_DBG_EN
   input  logic [ADDR_W-1:0]   dbg_raddr,
   output logic [DATA_W-1:0]   dbg_rdata,
   output logic [RF_CNT_W-1:0] dbg_wr_cnt,
`endif
   risc32_regfile_if.slave     rf
);

   logic [DATA_W-1:0] gpr [NUM_REGS];
   logic              gpr_wr;

   assign gpr_wr = (rf.we == WRITE_ENABLE) && (rf.waddr != '0);

   // NOTE: the whole array is cleared by reset, so it maps to flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      end else if (gpr_wr) begin
         gpr[rf.waddr] <= rf.wdata;
      end
   end

   function automatic logic [DATA_W-1:0] read_mux(
      input logic              rst_ok,
      input logic              re,
      input logic [ADDR_W-1:0] raddr,
      input logic              wr,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] value;
      value = '0;
      if (rst_ok && re == READ_ENABLE && raddr != '0) begin
         // A commit to the same register this cycle wins over the stored copy.
         value = (wr && waddr == raddr) ? wdata : stored;
      end
      return value;
   endfunction

   always_comb begin
      rf.rdata1 = read_mux(rst_n, rf.re1, rf.raddr1, gpr_wr, rf.waddr, rf.wdata, gpr[rf.raddr1]);
      rf.rdata2 = read_mux(rst_n, rf.re2, rf.raddr2, gpr_wr, rf.waddr, rf.wdata, gpr[rf.raddr2]);
   end

   risc32_hilo_reg #(.DATA_W(DATA_W)) u_hilo (
      .clk   (clk),
      .rst_n (rst_n),
      .whilo (rf.whilo),
      .hi_i  (rf.hi_i),
      .lo_i  (rf.lo_i),
      .hi_o  (rf.hi_o),
      .lo_o  (rf.lo_o)
   );

`ifdef RISC32_RF_DBG_EN
   assign dbg_rdata = gpr[dbg_raddr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_wr_cnt <= '0;
      end else if (gpr_wr) begin
         dbg_wr_cnt <= dbg_wr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_risc32_regfile.sv
// Self-checking bench for risc32_regfile: directed cases plus randomized traffic against an array model.
module tb_risc32_regfile;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   risc32_regfile_if rf_if ();

`ifdef RISC32_RF_DBG_EN
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;
   logic [31:0] dbg_wr_cnt;
`endif

   risc32_regfile dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef RISC32_RF_DBG_EN
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata),
      .dbg_wr_cnt (dbg_wr_cnt),
`endif
      .rf         (rf_if.slave)
   );

   // Reference model: architectural state as plain arrays/variables.
   logic [31:0] m_gpr [32];
   logic [31:0] m_hi, m_lo, m_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_cnt = '0;
   endtask

   function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
      if (!rst_n || !re || ra == 0) return '0;
      if (rf_if.we && rf_if.waddr == ra && rf_if.waddr != 0) return rf_if.wdata;
      return m_gpr[ra];
   endfunction

   task automatic idle_inputs();
      rf_if.we = 0; rf_if.waddr = 0; rf_if.wdata = 0;
      rf_if.re1 = 0; rf_if.raddr1 = 0; rf_if.re2 = 0; rf_if.raddr2 = 0;
      rf_if.whilo = 0; rf_if.hi_i = 0; rf_if.lo_i = 0;
`ifdef RISC32_RF_DBG_EN
      dbg_raddr = 0;
`endif
   endtask

   task automatic check_outputs(input string tag);
      #1;
      check({tag, ".rdata1"}, rf_if.rdata1, exp_read(rf_if.re1, rf_if.raddr1));
      check({tag, ".rdata2"}, rf_if.rdata2, exp_read(rf_if.re2, rf_if.raddr2));
      check({tag, ".hi_o"}, rf_if.hi_o, !rst_n ? 32'h0 : (rf_if.whilo ? rf_if.hi_i : m_hi));
      check({tag, ".lo_o"}, rf_if.lo_o, !rst_n ? 32'h0 : (rf_if.whilo ? rf_if.lo_i : m_lo));
`ifdef RISC32_RF_DBG_EN
      check({tag, ".dbg_rdata"}, dbg_rdata, m_gpr[dbg_raddr]);
      check({tag, ".dbg_wr_cnt"}, dbg_wr_cnt, m_cnt);
`endif
   endtask

   // Inputs are set after a negedge; check, clock, commit to the model, return at the next negedge.
   task automatic step(input string tag);
      check_outputs(tag);
      @(posedge clk);
      if (rst_n) begin
         if (rf_if.we && rf_if.waddr != 0) begin
            m_gpr[rf_if.waddr] = rf_if.wdata;
            m_cnt++;
         end
         if (rf_if.whilo) begin
            m_hi = rf_if.hi_i;
            m_lo = rf_if.lo_i;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset: every register reads zero on both ports.
      rf_if.re1 = 1; rf_if.re2 = 1;
      for (int r = 1; r < 32; r++) begin
         rf_if.raddr1 = r[4:0];
         rf_if.raddr2 = 5'(31 - r + 1);
         #1;
         check("rst.rdata1", rf_if.rdata1, 32'h0);
         check("rst.rdata2", rf_if.rdata2, 32'h0);
      end
      check("rst.hi_o", rf_if.hi_o, 32'h0);
      check("rst.lo_o", rf_if.lo_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain write then read on both ports.
      idle_inputs();
      rf_if.we = 1; rf_if.waddr = 5; rf_if.wdata = 32'hDEADBEEF;
      step("wr5");
      idle_inputs();
      rf_if.re1 = 1; rf_if.raddr1 = 5; rf_if.re2 = 1; rf_if.raddr2 = 5;
      #1;
      check("rd5.rdata1", rf_if.rdata1, 32'hDEADBEEF);
      check("rd5.rdata2", rf_if.rdata2, 32'hDEADBEEF);
      step("rd5");

      // Write to r0 is dropped and never bypassed.
      idle_inputs();
      rf_if.we = 1; rf_if.waddr = 0; rf_if.wdata = 32'h12345678;
      rf_if.re1 = 1; rf_if.raddr1 = 0;
      #1;
      check("r0.same", rf_if.rdata1, 32'h0);
      step("r0w");
      idle_inputs();
      rf_if.re1 = 1; rf_if.raddr1 = 0;
      #1;
      check("r0.next", rf_if.rdata1, 32'h0);
      step("r0r");

      // Same-cycle bypass, then stored value, then disabled port.
      idle_inputs();
      rf_if.we = 1; rf_if.waddr = 7; rf_if.wdata = 32'h11;
      step("wr7a");
      rf_if.wdata = 32'h22; rf_if.re1 = 1; rf_if.raddr1 = 7; rf_if.re2 = 1; rf_if.raddr2 = 7;
      #1;
      check("byp.rdata1", rf_if.rdata1, 32'h22);
      check("byp.rdata2", rf_if.rdata2, 32'h22);
      step("byp");
      rf_if.we = 0;
      #1;
      check("byp.after", rf_if.rdata1, 32'h22);
      rf_if.re1 = 0;
      #1;
      check("byp.re0", rf_if.rdata1, 32'h0);
      step("byp2");

      // HI/LO write-through, hold, and a concurrent GPR write.
      idle_inputs();
      rf_if.whilo = 1; rf_if.hi_i = 32'hA; rf_if.lo_i = 32'hB;
      rf_if.we = 1; rf_if.waddr = 9; rf_if.wdata = 32'h99;
      #1;
      check("hilo.hi", rf_if.hi_o, 32'hA);
      check("hilo.lo", rf_if.lo_o, 32'hB);
      step("hilo");
      idle_inputs();
      rf_if.re1 = 1; rf_if.raddr1 = 9;
      rf_if.hi_i = 32'hFFFF; rf_if.lo_i = 32'hEEEE;
      #1;
      check("hilo.hold_hi", rf_if.hi_o, 32'hA);
      check("hilo.hold_lo", rf_if.lo_o, 32'hB);
      check("hilo.gpr9", rf_if.rdata1, 32'h99);
      step("hilo2");

      // Asynchronous reset between edges wipes state at once; writes during reset are lost.
      idle_inputs();
      rf_if.we = 1; rf_if.waddr = 3; rf_if.wdata = 32'h55;
      step("wr3");
      idle_inputs();
      rf_if.re1 = 1; rf_if.raddr1 = 3;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.r3", rf_if.rdata1, 32'h0);
      rf_if.we = 1; rf_if.wdata = 32'h77; rf_if.whilo = 1; rf_if.hi_i = 32'h1; rf_if.lo_i = 32'h2;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      rf_if.re1 = 1; rf_if.raddr1 = 3;
      #1;
      check("arst.after_r3", rf_if.rdata1, 32'h0);
      check("arst.after_hi", rf_if.hi_o, 32'h0);
      step("arst");

      // Randomized traffic, biased toward a few registers so bypass and overwrites are frequent.
      for (int c = 0; c < 2000; c++) begin
         rf_if.we     = ($urandom_range(0, 2) != 0);
         rf_if.waddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rf_if.wdata  = $urandom;
         rf_if.re1    = ($urandom_range(0, 5) != 0);
         rf_if.raddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rf_if.re2    = ($urandom_range(0, 5) != 0);
         rf_if.raddr2 = ($urandom_range(0, 2) == 0) ? rf_if.waddr : 5'($urandom);
         rf_if.whilo  = ($urandom_range(0, 3) == 0);
         rf_if.hi_i   = $urandom;
         rf_if.lo_i   = $urandom;
`ifdef RISC32_RF_DBG_EN
         dbg_raddr    = 5'($urandom);
`endif
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
